// File: rtl/spw_router_pkg.sv
// Shared definitions for the SpaceWire-style router: character encoding
// and the per-input packet FSM state type.
package spw_router_pkg;
   localparam int CHAR_W   = 9;
   localparam int CTRL_BIT = 8;
   localparam logic [7:0] EOP_CODE = 8'h00;
   localparam logic [7:0] EEP_CODE = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_XFER,
      ST_DISCARD
   } in_state_t;

   function automatic logic is_ctrl(input logic [CHAR_W-1:0] c);
      return c[CTRL_BIT];
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held while
// i_hold stays high; the pointer moves past each new winner.
module rr_arbiter #(
   parameter int COUNT  = 8,
   parameter int ADDR_W = $clog2(COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COUNT-1:0] i_req,
   input  logic             i_hold,
   output logic [COUNT-1:0] o_win,
   output logic [COUNT-1:0] o_grant
);
   logic [COUNT-1:0]  r_grant;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_next;
   logic              w_found;

   // Decisions are only taken while the output is free.
   always_comb begin
      o_win      = '0;
      w_found    = 1'b0;
      w_ptr_next = r_ptr;
      if (r_grant == '0) begin
         for (int k = 0; k < COUNT; k++) begin
            if (!w_found && i_req[ADDR_W'((int'(r_ptr) + k) % COUNT)]) begin
               w_found = 1'b1;
               o_win[ADDR_W'((int'(r_ptr) + k) % COUNT)] = 1'b1;
               w_ptr_next = ADDR_W'((int'(r_ptr) + k + 1) % COUNT);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant <= '0;
         r_ptr   <= '0;
      end else if (r_grant != '0) begin
         if (!i_hold) r_grant <= '0;
      end else if (w_found) begin
         r_grant <= o_win;
         r_ptr   <= w_ptr_next;
      end
   end

   assign o_grant = r_grant;
endmodule

// File: rtl/spw_switch_matrix.sv
// Packet switch: each input strips a one-byte address header and is
// circuit-connected to its target output until the packet terminator passes.
module spw_switch_matrix
   import spw_router_pkg::*;
#(
   parameter int COUNT  = 8,
   parameter int ADDR_W = $clog2(COUNT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [COUNT*CHAR_W-1:0] in_data,
   input  logic [COUNT-1:0]        in_valid,
   output logic [COUNT-1:0]        in_ready,
   output logic [COUNT*CHAR_W-1:0] out_data,
   output logic [COUNT-1:0]        out_valid,
   input  logic [COUNT-1:0]        out_ready,
   output logic [COUNT-1:0]        drop
);
   logic [COUNT-1:0]              w_is_req;
   logic [COUNT-1:0]              w_eop_xfer;
   logic [COUNT-1:0]              w_granted;
   logic [COUNT-1:0]              w_hold;
   logic [COUNT-1:0][ADDR_W-1:0]  w_target;
   logic [COUNT-1:0][COUNT-1:0]   w_req;    // [output][input]
   logic [COUNT-1:0][COUNT-1:0]   w_win;    // [output][input]
   logic [COUNT-1:0][COUNT-1:0]   w_grant;  // [output][input]
   logic [COUNT-1:0][COUNT-1:0]   w_win_t;  // [input][output]

   genvar gi, gj;
   generate
      for (gi = 0; gi < COUNT; gi++) begin : g_in
         in_state_t         r_state, w_state_next;
         logic [ADDR_W-1:0] r_target, w_target_next;
         logic              r_drop, w_drop_next;
         logic              w_ready;
         logic [CHAR_W-1:0] w_char;

         assign w_char = in_data[gi*CHAR_W +: CHAR_W];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state  <= ST_IDLE;
               r_target <= '0;
               r_drop   <= 1'b0;
            end else begin
               r_state  <= w_state_next;
               r_target <= w_target_next;
               r_drop   <= w_drop_next;
            end
         end

         always_comb begin
            w_state_next  = r_state;
            w_target_next = r_target;
            w_drop_next   = 1'b0;
            w_ready       = 1'b0;
            case (r_state)
               ST_IDLE: begin
                  w_ready = 1'b1;
                  // Control chars here are empty packets and simply vanish.
                  if (in_valid[gi] && !is_ctrl(w_char)) begin
                     if (int'(w_char[7:0]) < COUNT) begin
                        w_state_next  = ST_REQ;
                        w_target_next = w_char[ADDR_W-1:0];
                     end else begin
                        w_state_next = ST_DISCARD;
                        w_drop_next  = 1'b1;
                     end
                  end
               end
               ST_REQ: begin
                  if (w_granted[gi]) w_state_next = ST_XFER;
               end
               ST_XFER: begin
                  w_ready = out_ready[r_target];
                  if (in_valid[gi] && out_ready[r_target] && is_ctrl(w_char))
                     w_state_next = ST_IDLE;
               end
               ST_DISCARD: begin
                  w_ready = 1'b1;
                  if (in_valid[gi] && is_ctrl(w_char)) w_state_next = ST_IDLE;
               end
               default: w_state_next = ST_IDLE;
            endcase
         end

         assign in_ready[gi]   = w_ready & ~rst;
         assign drop[gi]       = r_drop;
         assign w_is_req[gi]   = (r_state == ST_REQ);
         assign w_target[gi]   = r_target;
         assign w_granted[gi]  = |w_win_t[gi];
         assign w_eop_xfer[gi] = (r_state == ST_XFER) && in_valid[gi] &&
                                 out_ready[r_target] && is_ctrl(w_char);
      end

      for (gi = 0; gi < COUNT; gi++) begin : g_out
         logic [CHAR_W-1:0] w_mux_data;
         logic              w_mux_valid;

         for (gj = 0; gj < COUNT; gj++) begin : g_xbar
            assign w_req[gi][gj]   = w_is_req[gj] && (w_target[gj] == ADDR_W'(gi));
            assign w_win_t[gj][gi] = w_win[gi][gj];
         end

         // Release the output on the cycle its owner's terminator transfers.
         assign w_hold[gi] = ~|(w_grant[gi] & w_eop_xfer);

         rr_arbiter #(
            .COUNT  (COUNT),
            .ADDR_W (ADDR_W)
         ) u_arb (
            .clk     (clk),
            .rst     (rst),
            .i_req   (w_req[gi]),
            .i_hold  (w_hold[gi]),
            .o_win   (w_win[gi]),
            .o_grant (w_grant[gi])
         );

         always_comb begin
            w_mux_data  = '0;
            w_mux_valid = 1'b0;
            for (int k = 0; k < COUNT; k++) begin
               if (w_grant[gi][k]) begin
                  w_mux_data  = w_mux_data | in_data[k*CHAR_W +: CHAR_W];
                  w_mux_valid = w_mux_valid | in_valid[k];
               end
            end
         end

         assign out_data[gi*CHAR_W +: CHAR_W] = w_mux_data;
         assign out_valid[gi]                 = w_mux_valid;
      end
   endgenerate
endmodule

// File: doc/spw_switch_matrix.md
SPW_SWITCH_MATRIX -- requirements
Module: spw_switch_matrix

Interface
REQ-001 The module SHALL have parameter COUNT, default 8, meaning the number of router ports (2..32).
REQ-002 The module SHALL have parameter ADDR_W, default $clog2(COUNT), meaning the width of the port address used for routing.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_data, input, COUNT*9 bits: per-port receive char, bit8 = control flag, bits7:0 = data; control with bit0=0 is EOP, bit0=1 is EEP.
REQ-006 The module SHALL have port in_valid, input, COUNT bits: per-port receive char valid.
REQ-007 The module SHALL have port in_ready, output, COUNT bits: per-port receive char accepted.
REQ-008 The module SHALL have port out_data, output, COUNT*9 bits: per-port transmit char, same encoding as in_data.
REQ-009 The module SHALL have port out_valid, output, COUNT bits: per-port transmit char valid.
REQ-010 The module SHALL have port out_ready, input, COUNT bits: per-port transmit char accepted.
REQ-011 The module SHALL have port drop, output, COUNT bits: one-cycle pulse per input when a packet is discarded.

Function
REQ-012 A transfer SHALL occur on a port only in a cycle where valid and ready are both high.
REQ-013 Each input SHALL run an FSM with states IDLE, REQ, XFER and DISCARD.
REQ-014 In IDLE, in_ready SHALL be 1; a data char SHALL be taken as the header, registered as the target, and then deleted (never forwarded).
REQ-015 In IDLE, a control char (an empty packet) SHALL be consumed with no further action.
REQ-016 A header value below COUNT SHALL move the FSM IDLE->REQ; a value of COUNT or above SHALL move it IDLE->DISCARD and pulse drop[i] in the next cycle.
REQ-017 In DISCARD, in_ready SHALL be 1 and chars SHALL be dropped; the FSM SHALL return to IDLE on the cycle an EOP or EEP transfers.
REQ-018 In REQ, in_ready SHALL be 0 until the target output grants that input; then REQ->XFER.
REQ-019 Each output SHALL have a round-robin arbiter over the inputs in REQ targeting it, with the grant registered (effective the cycle after the decision).
REQ-020 The priority pointer SHALL reset to input 0 and SHALL advance to the granted index + 1, modulo COUNT.
REQ-021 In XFER, the datapath SHALL be combinational: out_data[o]=in_data[i], out_valid[o]=in_valid[i], in_ready[i]=out_ready[o].
REQ-022 An ungranted output SHALL drive out_valid=0 and out_data=0.
REQ-023 The grant SHALL be held until the EOP or EEP of the packet transfers; then XFER->IDLE and the output is freed, becoming arbitrable the next cycle.
REQ-024 Minimum latency SHALL be: header accepted at cycle N, first payload char visible on the output at cycle N+2.
REQ-025 Self-routing (input i to output i) SHALL be legal.
REQ-026 Disjoint input/output pairs SHALL run concurrently at one char per cycle each.

Reset
REQ-027 While rst is high: all FSMs SHALL be IDLE, all grants cleared, pointers at 0, out_valid=0, out_data=0, in_ready=0, drop=0.
REQ-028 The first cycle after rst deasserts, in_ready SHALL be all ones.
REQ-029 Reset during a packet SHALL abandon it silently; no EEP is inserted (the link layer handles termination).

Structure
REQ-030 Package spw_router_pkg SHALL hold CHAR_W=9, the control-flag bit index, the EOP/EEP codes and the input FSM state enum.
REQ-031 Sub-module rr_arbiter (COUNT requests, registered one-hot grant, hold input, rotating pointer) SHALL be instantiated once per output.

Verification
REQ-032 Route: in0 sends {0x03,0xA5,0x5A,EOP} -> out3 emits 0xA5,0x5A,EOP; 0x03 never appears; first char at header cycle +2.
REQ-033 Contention: in1 and in2 send header 0x05 in the same cycle after reset -> in1 is granted first and in_ready[2]=0 until in1's EOP transfers; in2 is granted afterward and the pointer ends at 3.
REQ-034 Bad address (COUNT=8): in4 sends {0x08,0x11,EEP} -> drop[4] pulses once, in_ready[4]=1 throughout, no out_valid anywhere.
REQ-035 Backpressure: out_ready[6] held low for 10 cycles mid-packet -> in_ready[src]=0 for those cycles; the output stream matches the input exactly, with no loss or duplication.
REQ-036 Reset: rst pulsed mid-XFER -> out_valid=0 asynchronously; after release, a new packet 0->1 routes correctly.
REQ-037 Parallel: 0->1 and 2->3 streams of 64 chars each -> both complete in 64 transfer cycles after the grants.
